// File: rtl/banked_mem_responder.sv
// ----------------------------------------------------------------------------
// banked_mem_responder
//   Responder end of the cache-to-memory interface. Models a four-bank,
//   word-interleaved main memory. Each bank accepts one request, then stays
//   occupied for BANK_OCC cycles (counting the acceptance cycle). Reads return
//   data exactly RD_LAT cycles after acceptance. A request to an occupied bank
//   is stalled combinationally so the initiator can re-present it. Illegal
//   requests (rd and wr together, or a misaligned address) are dropped and
//   flagged with a one-cycle registered error pulse.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset (storage is not cleared)
//   i_createdump dump request, no effect on outputs or timing in this model
//   i_addr       byte address; bank = addr[2:1], word = addr[ADDR_BITS-1:1]
//   i_data_in    write data
//   i_rd, i_wr   read / write request for this cycle
//   o_data_out   read data, valid RD_LAT cycles after acceptance, else 0
//   o_stall      request this cycle rejected because its bank is occupied
//   o_busy       o_busy[b] high while bank b is occupied
//   o_err        registered pulse flagging an illegal request last cycle
// ----------------------------------------------------------------------------
module banked_mem_responder #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned BANK_OCC  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_createdump,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [15:0]          i_data_in,
    input  logic                 i_rd,
    input  logic                 i_wr,
    output logic [15:0]          o_data_out,
    output logic                 o_stall,
    output logic [3:0]           o_busy,
    output logic                 o_err
);

    localparam int unsigned WORDS = 2 ** (ADDR_BITS - 1);
    localparam int unsigned CNT_W = (BANK_OCC > 2) ? $clog2(BANK_OCC) : 1;
    localparam logic [CNT_W-1:0] OCC_LOAD = CNT_W'(BANK_OCC - 1);

    logic [15:0]          r_mem  [WORDS];
    logic [CNT_W-1:0]     r_cnt  [4];
    logic [15:0]          r_pipe [RD_LAT];
    logic                 r_err;

    logic                 w_req;
    logic                 w_illegal;
    logic [1:0]           w_bank;
    logic [ADDR_BITS-2:0] w_word;
    logic                 w_bank_busy;
    logic                 w_accept;
    logic                 w_accept_rd;
    logic                 w_accept_wr;

    // The dump request is a simulation-side hook only; it is intentionally
    // not connected to any state.
    logic                 w_unused;
    assign w_unused = i_createdump;

    // ------------------------------------------------------------------
    // Request decode. The illegal check takes precedence over the busy
    // check, so an illegal request never raises stall.
    // ------------------------------------------------------------------
    always_comb begin
        w_req     = i_rd | i_wr;
        w_illegal = (i_rd & i_wr) | (w_req & i_addr[0]);
        w_bank    = i_addr[2:1];
        w_word    = i_addr[ADDR_BITS-1:1];
    end

    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            o_busy[b] = (r_cnt[b] != '0);
        end
    end

    always_comb begin
        w_bank_busy = o_busy[w_bank];
        o_stall     = w_req & ~w_illegal & w_bank_busy;
        w_accept    = w_req & ~w_illegal & ~w_bank_busy & ~i_rst;
        w_accept_rd = w_accept & i_rd;
        w_accept_wr = w_accept & i_wr;
    end

    // ------------------------------------------------------------------
    // Bank occupancy: loaded on acceptance, counts down to zero. Because
    // the counter reaches zero in the cycle BANK_OCC after acceptance, a
    // same-bank request in that cycle is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_accept && (w_bank == 2'(b))) begin
                    r_cnt[b] <= OCC_LOAD;
                end else if (r_cnt[b] != '0) begin
                    r_cnt[b] <= r_cnt[b] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Never touched by reset; only one acceptance per cycle, so a
    // read and a write to the same word cannot collide on one edge.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_accept_wr) begin
            r_mem[w_word] <= i_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Read return pipe. Non-read cycles push zero, so the output is zero
    // everywhere except the single valid cycle of each read.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_accept_rd ? r_mem[w_word] : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data_out = r_pipe[RD_LAT-1];

    // ------------------------------------------------------------------
    // Error pulse: registered copy of the illegal-request decode.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_illegal;
        end
    end

    assign o_err = r_err;

endmodule

// File: tb/tb_banked_mem_responder.sv
module tb_banked_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        createdump;
    logic [15:0] addr;
    logic [15:0] din;
    logic        rd;
    logic        wr;
    logic [15:0] dout;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    banked_mem_responder #(
        .ADDR_BITS (16),
        .RD_LAT    (2),
        .BANK_OCC  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_createdump (createdump),
        .i_addr       (addr),
        .i_data_in    (din),
        .i_rd         (rd),
        .i_wr         (wr),
        .o_data_out   (dout),
        .o_stall      (stall),
        .o_busy       (busy),
        .o_err        (err)
    );

    // ---------------- reference model (cycle-numbered) ----------------
    typedef struct {
        int          c;
        logic [15:0] d;
    } rd_t;

    logic [15:0] m_mem [int];
    int          m_acc [4];
    bit          m_err_next = 1'b0;
    rd_t         m_q [$];

    // Outputs expected during the current cycle, given its inputs.
    task automatic model_expect(input logic r_d, input logic w_r, input logic [15:0] a,
                                output logic [15:0] e_data, output logic e_stall,
                                output logic [3:0] e_busy, output logic e_err);
        bit ill;
        e_busy = 4'b0000;
        for (int b = 0; b < 4; b++)
            e_busy[b] = (cyc > m_acc[b]) && (cyc < m_acc[b] + 4);
        ill     = (r_d && w_r) || ((r_d || w_r) && a[0]);
        e_stall = (r_d || w_r) && !ill && e_busy[a[2:1]];
        e_err   = m_err_next;
        while (m_q.size() > 0 && m_q[0].c < cyc) void'(m_q.pop_front());
        e_data = (m_q.size() > 0 && m_q[0].c == cyc) ? m_q[0].d : 16'h0000;
    endtask

    task automatic model_update(input logic r, input logic r_d, input logic w_r,
                                input logic [15:0] a, input logic [15:0] d);
        bit ill;
        int b;
        int w;
        if (r) begin
            for (int i = 0; i < 4; i++) m_acc[i] = -100;
            m_err_next = 1'b0;
            m_q.delete();
            return;
        end
        ill = (r_d && w_r) || ((r_d || w_r) && a[0]);
        m_err_next = ill;
        b = int'(a[2:1]);
        w = int'(a[15:1]);
        if ((r_d || w_r) && !ill && !((cyc > m_acc[b]) && (cyc < m_acc[b] + 4))) begin
            m_acc[b] = cyc;
            if (w_r) m_mem[w] = d;
            if (r_d) m_q.push_back('{c: cyc + 2, d: (m_mem.exists(w) ? m_mem[w] : 16'h0000)});
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // mode 0: no check, 1: explicit expectations, 2: model expectations.
    // Entered and left just after a falling edge.
    task automatic step(input logic r, input logic r_d, input logic w_r,
                        input logic [15:0] a, input logic [15:0] d, input int mode,
                        input string tag, input logic [15:0] x_data, input logic x_stall,
                        input logic [3:0] x_busy, input logic x_err);
        logic [15:0] m_data;
        logic        m_stall;
        logic [3:0]  m_busy;
        logic        m_errv;
        rst = r; rd = r_d; wr = w_r; addr = a; din = d;
        #1;
        model_expect(r_d, w_r, a, m_data, m_stall, m_busy, m_errv);
        if (mode == 1) begin
            chk({tag, "_data"},  dout,          x_data);
            chk({tag, "_stall"}, 16'(stall),    16'(x_stall));
            chk({tag, "_busy"},  16'(busy),     16'(x_busy));
            chk({tag, "_err"},   16'(err),      16'(x_err));
        end else if (mode == 2) begin
            chk({tag, "_data"},  dout,          m_data);
            chk({tag, "_stall"}, 16'(stall),    16'(m_stall));
            chk({tag, "_busy"},  16'(busy),     16'(m_busy));
            chk({tag, "_err"},   16'(err),      16'(m_errv));
        end
        model_update(r, r_d, w_r, a, d);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] e_data;
        logic        e_stall;
        logic [3:0]  e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic r, input logic r_d, input logic w_r, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] ed, input logic es,
                       input logic [3:0] eb, input logic ee);
        vecs.push_back('{rst: r, rd: r_d, wr: w_r, addr: a, din: d,
                         e_data: ed, e_stall: es, e_busy: eb, e_err: ee});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_acc[i] = -100;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = '0; createdump = 1'b0;

        //   rst rd wr addr     din      data     stl busy     err
        // reset, then idle
        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        // write 0x0010, read it back at N+4
        add(0, 0, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        // fill banks 0..3, then stream reads across them
        add(0, 0, 1, 16'h0000, 16'h1111, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 1, 16'h0002, 16'h2222, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 1, 16'h0004, 16'h3333, 16'h0000, 0, 4'b0011, 0);
        add(0, 0, 1, 16'h0006, 16'h4444, 16'h0000, 0, 4'b0111, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b1110, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b1100, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b1000, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 1, 0, 16'h0002, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 1, 0, 16'h0004, 16'h0000, 16'h1111, 0, 4'b0011, 0);
        add(0, 1, 0, 16'h0006, 16'h0000, 16'h2222, 0, 4'b0111, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h3333, 0, 4'b1110, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h4444, 0, 4'b1100, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b1000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        // same-bank conflict: stall for three cycles, accepted at N+4
        add(0, 0, 1, 16'h0008, 16'h5555, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 1, 0, 16'h0008, 16'h0000, 16'h0000, 1, 4'b0001, 0);
        add(0, 1, 0, 16'h0008, 16'h0000, 16'h1111, 1, 4'b0001, 0);
        add(0, 1, 0, 16'h0008, 16'h0000, 16'h0000, 1, 4'b0001, 0);
        add(0, 1, 0, 16'h0008, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h5555, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0001, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        // illegal requests: no stall, no busy, err next cycle, storage untouched
        add(0, 1, 1, 16'h0004, 16'hDEAD, 16'h0000, 0, 4'b0000, 0);
        add(0, 1, 0, 16'h0003, 16'h0000, 16'h0000, 0, 4'b0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0000, 1);
        add(0, 1, 0, 16'h0004, 16'h0000, 16'h0000, 0, 4'b0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'b0100, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 16'h3333, 0, 4'b0100, 0);

        @(negedge clk);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, "init", 16'h0, 0, 4'b0, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 0, "init", 16'h0, 0, 4'b0, 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, 1,
                 $sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_stall,
                 vecs[i].e_busy, vecs[i].e_err);

        // reset while a read is in flight: data discarded, counters cleared
        step(0, 1, 0, 16'h0002, 16'h0000, 1, "rst6_a", 16'h0000, 0, 4'b0100, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 1, "rst6_b", 16'h0000, 0, 4'b0010, 0);
        step(0, 1, 0, 16'h0002, 16'h0000, 1, "rst6_c", 16'h0000, 0, 4'b0000, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 1, "rst6_d", 16'h0000, 0, 4'b0010, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 1, "rst6_e", 16'h2222, 0, 4'b0010, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 1, "rst6_f", 16'h0000, 0, 4'b0010, 0);
        step(0, 0, 0, 16'h0000, 16'h0000, 1, "rst6_g", 16'h0000, 0, 4'b0000, 0);

        // illegal request followed by reset: err pulse still appears, then clears
        step(0, 1, 1, 16'h0002, 16'h0000, 1, "errrst_a", 16'h0000, 0, 4'b0000, 0);
        step(1, 0, 0, 16'h0000, 16'h0000, 1, "errrst_b", 16'h0000, 0, 4'b0000, 1);
        step(0, 0, 0, 16'h0000, 16'h0000, 1, "errrst_c", 16'h0000, 0, 4'b0000, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        r_d;
            logic        w_r;
            logic [15:0] a;
            int          op;
            int          w;
            r   = ($urandom_range(0, 39) == 0);
            op  = $urandom_range(0, 9);
            w   = $urandom_range(0, 31);
            a   = 16'(w * 2);
            r_d = 1'b0;
            w_r = 1'b0;
            if (op >= 2 && op <= 5) r_d = 1'b1;
            else if (op >= 6 && op <= 8) w_r = 1'b1;
            else if (op == 9) begin
                if ($urandom_range(0, 1) == 0) begin
                    r_d = 1'b1; w_r = 1'b1;
                end else begin
                    r_d = 1'($urandom_range(0, 1));
                    w_r = ~r_d;
                    a[0] = 1'b1;
                end
            end
            // read only words already written, so the expected value never
            // depends on power-up contents
            if (r_d && !w_r && !a[0] && !m_mem.exists(w)) begin
                r_d = 1'b0; w_r = 1'b1;
            end
            if (r) begin
                r_d = 1'b0; w_r = 1'b0;
            end
            step(r, r_d, w_r, a, 16'($urandom), 2, "rand", 16'h0, 0, 4'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
